hazard_ctrl_pipe: RTL

HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

---
 rtl/hazard_ctrl_pipe_if.sv | 46 ++++
 rtl/hazard_ctrl_pipe.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_pipe_if.sv
// Hazard controller port bundle.
// Pipeline-side hazard inputs and controller-side stall/flush outputs.
interface hazard_ctrl_pipe_if #(
  parameter int RW = 5,
  parameter int CW = 16
);
  logic          ID_EXmemRead;
  logic          ID_EXmulti;
  logic [RW-1:0] ID_EXrd;
  logic [RW-1:0] IF_IDrs1;
  logic [RW-1:0] IF_IDrs2;
  logic          IF_IDrs1_used;
  logic          IF_IDrs2_used;
  logic          branch_taken;
  logic          PCwrite;
  logic          IF_IDwrite;
  logic          regWrite;
  logic          memWrite;
  logic          ID_EXwrite;
  logic          IF_IDflush;
  logic          ID_EXflush;
  logic          stall_busy;
  logic [CW-1:0] stall_cycles;

  modport master (
    output ID_EXmemRead, ID_EXmulti, ID_EXrd,
    output IF_IDrs1, IF_IDrs2,
    output IF_IDrs1_used, IF_IDrs2_used,
    output branch_taken,
    input  PCwrite, IF_IDwrite, regWrite,
    input  memWrite, ID_EXwrite,
    input  IF_IDflush, ID_EXflush,
    input  stall_busy, stall_cycles
  );

  modport slave (
    input  ID_EXmemRead, ID_EXmulti, ID_EXrd,
    input  IF_IDrs1, IF_IDrs2,
    input  IF_IDrs1_used, IF_IDrs2_used,
    input  branch_taken,
    output PCwrite, IF_IDwrite, regWrite,
    output memWrite, ID_EXwrite,
    output IF_IDflush, ID_EXflush,
    output stall_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// Pipeline hazard controller: load-use stall,
// multi-cycle EX freeze, branch flush, stall counter.
module hazard_ctrl_pipe #(
  parameter int RW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4,
  parameter int CW       = 16
) (
  input  logic clk,
  input  logic reset,
  hazard_ctrl_pipe_if.slave bus
);

  localparam int MAXL =
    (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
  localparam int NW = $clog2(MAXL) + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LD_STALL = 2'd1;
  localparam logic [1:0] MC_BUSY  = 2'd2;
  localparam logic [1:0] MC_REL   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] stall_cycles_q, stall_cycles_d;
  logic          hazard;
  logic          pc_w, ifid_w, reg_w, mem_w, idex_w;
  logic          ifid_f, idex_f;

  // Load-use match; register 0 never hazards.
  always_comb begin
    hazard = bus.ID_EXmemRead
           && (bus.ID_EXrd != '0)
           && ((bus.IF_IDrs1_used
                && bus.ID_EXrd == bus.IF_IDrs1)
            || (bus.IF_IDrs2_used
                && bus.ID_EXrd == bus.IF_IDrs2));
  end

  // Next state, counter and control outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    reg_w   = 1'b1;
    mem_w   = 1'b1;
    idex_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_f  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.branch_taken) begin
          ifid_f = 1'b1;
          idex_f = 1'b1;
          cnt_d  = '0;
        end else if (bus.ID_EXmulti) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_w = 1'b0;
          if (MC_LAT > 2) begin
            state_d = MC_BUSY;
            cnt_d   = NW'(MC_LAT - 2);
          end else begin
            state_d = MC_REL;
          end
        end else if (hazard) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          reg_w  = 1'b0;
          mem_w  = 1'b0;
          if (LOAD_LAT > 1) begin
            state_d = LD_STALL;
            cnt_d   = NW'(LOAD_LAT - 1);
          end
        end
      end
      LD_STALL: begin
        if (bus.branch_taken) begin
          ifid_f  = 1'b1;
          idex_f  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          reg_w  = 1'b0;
          mem_w  = 1'b0;
          cnt_d  = cnt_q - NW'(1);
          if (cnt_q == NW'(1)) state_d = IDLE;
        end
      end
      MC_BUSY: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_w = 1'b0;
        cnt_d  = cnt_q - NW'(1);
        if (cnt_q == NW'(1)) state_d = MC_REL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating count of cycles with the PC held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_w && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + CW'(1);
  end

  // State, counter and stall counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.PCwrite      = pc_w;
  assign bus.IF_IDwrite   = ifid_w;
  assign bus.regWrite     = reg_w;
  assign bus.memWrite     = mem_w;
  assign bus.ID_EXwrite   = idex_w;
  assign bus.IF_IDflush   = ifid_f;
  assign bus.ID_EXflush   = idex_f;
  assign bus.stall_busy   = (state_q != IDLE);
  assign bus.stall_cycles = stall_cycles_q;

endmodule
